k6502_joypad_port: RTL and testbench

// - CPU-bus responder for the two NES controller ports at $4016/$4017.
// - Sits on the far side of the k6502 address/data buses: decodes the CPU address,

---
 rtl/k6502_joypad_port.sv | 100 ++++++++++
 tb/tb_k6502_joypad_port.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/k6502_joypad_port.sv
// NES controller port responder at $4016/$4017: strobe latch plus two serial shift registers.
// Optional macro JOYPAD_SYNC_EN adds a 2-flop synchronizer on the button inputs.
module k6502_joypad_port #(
  parameter logic [15:0] PORT0_ADDR = 16'h4016,
  parameter logic [15:0] PORT1_ADDR = 16'h4017,
  parameter logic [7:0]  OPEN_BUS   = 8'h40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cycle_en,
  input  logic [15:0] a,
  input  logic        rw,
  input  logic [7:0]  d_in,
  output logic [7:0]  d_out,
  output logic        d_oe,
  input  logic [7:0]  pad0_buttons,
  input  logic [7:0]  pad1_buttons
);

  logic [7:0] btn0;
  logic [7:0] btn1;
  logic       strobe;
  logic [7:0] sr0;
  logic [7:0] sr1;
  logic       sel0;
  logic       sel1;
  logic       rd_bit;

  // Only d_in[0] carries the strobe; upper write-data bits have no meaning here.
  logic unused_d_in;
  assign unused_d_in = ^d_in[7:1];

`ifdef JOYPAD_SYNC_EN
  logic [7:0] btn0_p0;
  logic [7:0] btn0_p1;
  logic [7:0] btn1_p0;
  logic [7:0] btn1_p1;

  // Button pins are asynchronous to clk; free-running two-stage synchronizer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn0_p0 <= 8'h00;
      btn0_p1 <= 8'h00;
      btn1_p0 <= 8'h00;
      btn1_p1 <= 8'h00;
    end else begin
      btn0_p0 <= pad0_buttons;
      btn0_p1 <= btn0_p0;
      btn1_p0 <= pad1_buttons;
      btn1_p1 <= btn1_p0;
    end
  end

  assign btn0 = btn0_p1;
  assign btn1 = btn1_p1;
`else
  assign btn0 = pad0_buttons;
  assign btn1 = pad1_buttons;
`endif

  assign sel0 = (a == PORT0_ADDR);
  assign sel1 = (a == PORT1_ADDR);

  always_comb begin
    rd_bit = 1'b0;
    if (sel0) begin
      rd_bit = strobe ? btn0[0] : sr0[0];
    end else if (sel1) begin
      rd_bit = strobe ? btn1[0] : sr1[0];
    end
  end

  assign d_oe  = rst_n & rw & (sel0 | sel1);
  assign d_out = d_oe ? ((OPEN_BUS & 8'hFE) | {7'b0, rd_bit}) : 8'h00;

  // Reload tests the pre-write strobe, so a 1->0 write still captures the buttons.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      strobe <= 1'b0;
      sr0    <= 8'h00;
      sr1    <= 8'h00;
    end else if (cycle_en) begin
      if (strobe) begin
        sr0 <= btn0;
        sr1 <= btn1;
      end else begin
        if (rw && sel0) begin
          sr0 <= {1'b1, sr0[7:1]};
        end
        if (rw && sel1) begin
          sr1 <= {1'b1, sr1[7:1]};
        end
      end
      if (!rw && sel0) begin
        strobe <= d_in[0];
      end
    end
  end

endmodule

// File: tb/tb_k6502_joypad_port.sv
// Directed bench for k6502_joypad_port: vector table plus hand sequences for strobe and reset corners.
module tb_k6502_joypad_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cycle_en;
  logic [15:0] a;
  logic        rw;
  logic [7:0]  d_in;
  logic [7:0]  d_out;
  logic        d_oe;
  logic [7:0]  pad0_buttons;
  logic [7:0]  pad1_buttons;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  k6502_joypad_port dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cycle_en     (cycle_en),
    .a            (a),
    .rw           (rw),
    .d_in         (d_in),
    .d_out        (d_out),
    .d_oe         (d_oe),
    .pad0_buttons (pad0_buttons),
    .pad1_buttons (pad1_buttons)
  );

  typedef struct {
    logic        cyc;
    logic [15:0] addr;
    logic        rd;
    logic [7:0]  wdata;
    logic        exp_oe;
    logic [7:0]  exp_dout;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic cyc, input logic [15:0] addr, input logic rd,
                     input logic [7:0] wdata, input logic exp_oe, input logic [7:0] exp_dout);
    vec_t v;
    v.cyc = cyc; v.addr = addr; v.rd = rd; v.wdata = wdata;
    v.exp_oe = exp_oe; v.exp_dout = exp_dout;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic exp_oe, input logic [7:0] exp_dout);
    checks++;
    if (d_oe !== exp_oe || d_out !== exp_dout) begin
      errors++;
      $display("FAIL %s: got oe=%0b dout=%02h, want oe=%0b dout=%02h",
               name, d_oe, d_out, exp_oe, exp_dout);
    end
  endtask

  // One bus cycle: drive after negedge, compare mid-low phase, state updates at posedge.
  task automatic bus(input logic cyc, input logic [15:0] addr, input logic rd,
                     input logic [7:0] wdata, input logic do_chk, input logic exp_oe,
                     input logic [7:0] exp_dout, input string name);
    @(negedge clk);
    cycle_en = cyc; a = addr; rw = rd; d_in = wdata;
    #2;
    if (do_chk) check(name, exp_oe, exp_dout);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(1'b1, 16'h0000, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, "idle");
  endtask

  initial begin
    rst_n = 1'b0; cycle_en = 1'b0; a = 16'h0000; rw = 1'b1; d_in = 8'h00;
    pad0_buttons = 8'h85; pad1_buttons = 8'h02;

    add(1, 16'h4016, 1, 8'h00, 1, 8'h40);  // after reset: sr0=0
    add(1, 16'h2000, 1, 8'h00, 0, 8'h00);  // unselected address
    add(0, 16'h4017, 1, 8'h00, 1, 8'h40);  // decode ignores cycle_en
    add(1, 16'h4017, 0, 8'h01, 0, 8'h00);  // $4017 write: no drive, no strobe
    add(1, 16'h4016, 1, 8'h00, 1, 8'h40);  // strobe still 0
    add(1, 16'h0000, 1, 8'h00, 0, 8'h00);
    add(1, 16'h0000, 1, 8'h00, 0, 8'h00);
    add(1, 16'h4016, 0, 8'hFF, 0, 8'h00);  // strobe 1
    add(1, 16'h4016, 0, 8'h00, 0, 8'h00);  // strobe 0, captures 85/02
    add(1, 16'h4016, 1, 8'h00, 1, 8'h41);
    add(1, 16'h4016, 1, 8'h00, 1, 8'h40);
    add(1, 16'h4016, 1, 8'h00, 1, 8'h41);
    add(1, 16'h4016, 1, 8'h00, 1, 8'h40);
    add(1, 16'h4016, 1, 8'h00, 1, 8'h40);
    add(1, 16'h4016, 1, 8'h00, 1, 8'h40);
    add(1, 16'h4016, 1, 8'h00, 1, 8'h40);
    add(1, 16'h4016, 1, 8'h00, 1, 8'h41);
    add(1, 16'h4016, 1, 8'h00, 1, 8'h41);  // read 9
    add(1, 16'h4016, 1, 8'h00, 1, 8'h41);  // read 10
    add(1, 16'h4017, 1, 8'h00, 1, 8'h40);  // pad1 = 02
    add(1, 16'h4017, 1, 8'h00, 1, 8'h41);
    add(1, 16'h4016, 0, 8'h01, 0, 8'h00);
    add(1, 16'h4016, 0, 8'h00, 0, 8'h00);
    add(1, 16'h4017, 1, 8'h00, 1, 8'h40);
    add(1, 16'h4017, 1, 8'h00, 1, 8'h41);
    add(1, 16'h4016, 1, 8'h00, 1, 8'h41);  // sr0 unshifted by port1 reads
    add(1, 16'h4016, 1, 8'h00, 1, 8'h40);
    add(1, 16'h4016, 0, 8'h01, 0, 8'h00);  // strobe held high
    add(1, 16'h4016, 1, 8'h00, 1, 8'h41);
    add(1, 16'h4016, 1, 8'h00, 1, 8'h41);
    add(1, 16'h4016, 0, 8'h00, 0, 8'h00);
    add(1, 16'h4016, 1, 8'h00, 1, 8'h41);  // A, nothing shifted while strobed
    add(1, 16'h4016, 1, 8'h00, 1, 8'h40);  // B
    add(0, 16'h4016, 0, 8'h01, 0, 8'h00);  // write without cycle_en is dropped
    add(1, 16'h4016, 1, 8'h00, 1, 8'h41);  // Select
    add(1, 16'h4016, 1, 8'h00, 1, 8'h40);  // Start

    @(negedge clk);
    #2 check("reset_oe_low", 1'b0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    idle(0);

    for (int i = 0; i < vecs.size(); i++) begin
      bus(vecs[i].cyc, vecs[i].addr, vecs[i].rd, vecs[i].wdata, 1'b1,
          vecs[i].exp_oe, vecs[i].exp_dout, $sformatf("vec%0d", i));
    end

`ifndef JOYPAD_SYNC_EN
    // Strobe held: reads follow live A, and the falling write latches the pins at that edge.
    bus(1, 16'h4016, 0, 8'h01, 0, 0, 8'h00, "");
    for (int i = 0; i < 3; i++) begin
      pad0_buttons = (i % 2 == 0) ? 8'h84 : 8'h85;
      bus(1, 16'h4016, 1, 8'h00, 1, 1'b1, (i % 2 == 0) ? 8'h40 : 8'h41,
          $sformatf("live_a%0d", i));
    end
    pad0_buttons = 8'h02;
    bus(1, 16'h4016, 0, 8'h00, 0, 0, 8'h00, "");
    bus(1, 16'h4016, 1, 8'h00, 1, 1'b1, 8'h40, "latched_a");
    bus(1, 16'h4016, 1, 8'h00, 1, 1'b1, 8'h41, "latched_b");
    pad0_buttons = 8'h85;
`else
    // Synchronizer lag: a pin change one clk before the falling strobe is not yet visible.
    pad0_buttons = 8'h84;
    idle(3);
    bus(1, 16'h4016, 0, 8'h01, 0, 0, 8'h00, "");
    pad0_buttons = 8'h85;
    bus(1, 16'h4016, 0, 8'h00, 0, 0, 8'h00, "");
    bus(1, 16'h4016, 1, 8'h00, 1, 1'b1, 8'h40, "sync_old_a");
    bus(1, 16'h4016, 0, 8'h01, 0, 0, 8'h00, "");
    idle(2);
    bus(1, 16'h4016, 0, 8'h00, 0, 0, 8'h00, "");
    bus(1, 16'h4016, 1, 8'h00, 1, 1'b1, 8'h41, "sync_new_a");
`endif

    // Reset in the middle of a read-out sequence.
    idle(2);
    bus(1, 16'h4016, 0, 8'h01, 0, 0, 8'h00, "");
    bus(1, 16'h4016, 0, 8'h00, 0, 0, 8'h00, "");
    for (int i = 0; i < 3; i++) bus(1, 16'h4016, 1, 8'h00, 0, 0, 8'h00, "");
    @(negedge clk);
    cycle_en = 1'b1; a = 16'h4016; rw = 1'b1; rst_n = 1'b0;
    #2 check("mid_reset_oe_low", 1'b0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #2 check("post_reset_read", 1'b1, 8'h40);
    bus(1, 16'h4017, 0, 8'h01, 0, 0, 8'h00, "");
    idle(2);
    bus(1, 16'h4016, 1, 8'h00, 1, 1'b1, 8'h40, "p1_write_no_strobe");

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
